// File: rtl/marlann_pkg.sv
// Shared definitions for the marlann compute core and its memory responder.
// Holds the core-facing bus widths, the read latency the core pipeline
// assumes, and the state encoding of the memory's clear/run sequencer.
package marlann_pkg;

  localparam int MARLANN_DATA_W = 64;
  localparam int MARLANN_ADDR_W = 16;
  localparam int MARLANN_BE_W   = 8;
  localparam int MARLANN_RD_LAT = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } marlann_state_e;

endpackage

// File: rtl/marlann_memory_if.sv
// Bus bundle between the compute core / host and marlann_memory.
// Core side: mem_ren, mem_wen, mem_addr, mem_wdata -> mem_rdata.
// Host side: host_valid/host_ready handshake with host_wen, host_addr,
// host_wdata; read results come back on host_rvalid/host_rdata.
// The memory uses modport slave; whatever drives requests uses master.
interface marlann_memory_if;
  import marlann_pkg::*;

  logic                      mem_ren;
  logic [MARLANN_BE_W-1:0]   mem_wen;
  logic [MARLANN_ADDR_W-1:0] mem_addr;
  logic [MARLANN_DATA_W-1:0] mem_wdata;
  logic [MARLANN_DATA_W-1:0] mem_rdata;

  logic                      host_valid;
  logic                      host_ready;
  logic [MARLANN_BE_W-1:0]   host_wen;
  logic [MARLANN_ADDR_W-1:0] host_addr;
  logic [MARLANN_DATA_W-1:0] host_wdata;
  logic                      host_rvalid;
  logic [MARLANN_DATA_W-1:0] host_rdata;

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    output mem_rdata,
    input  host_valid, host_wen, host_addr, host_wdata,
    output host_ready, host_rvalid, host_rdata
  );

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    input  mem_rdata,
    output host_valid, host_wen, host_addr, host_wdata,
    input  host_ready, host_rvalid, host_rdata
  );

endinterface

// File: rtl/marlann_memory_ram.sv
// Single-port data RAM with per-byte write enables and a registered read.
// Ports: clock; ren_i read strobe; wen_i byte enables (bit i -> byte i);
// addr_i word address; wdata_i write data; rdata_o registered read data.
// A read and write to the same word in one cycle returns the old contents.
// Contents are never reset.
module marlann_memory_ram
  import marlann_pkg::*;
#(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input  logic                      clock,
  input  logic                      ren_i,
  input  logic [MARLANN_BE_W-1:0]   wen_i,
  input  logic [AW-1:0]             addr_i,
  input  logic [MARLANN_DATA_W-1:0] wdata_i,
  output logic [MARLANN_DATA_W-1:0] rdata_o
);

  logic [MARLANN_DATA_W-1:0] mem_q [WORDS];
  logic [MARLANN_DATA_W-1:0] rdata_q;

  // Read samples the array before this edge's write lands (read-first).
  always_ff @(posedge clock) begin
    if (ren_i) rdata_q <= mem_q[addr_i];
    for (int i = 0; i < MARLANN_BE_W; i++) begin
      if (wen_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/marlann_memory.sv
// Data memory responder for the marlann compute core.
// Ports: clock, resetn (async, active-low); busy while the post-reset clear
// runs; clear_err sticky flag for core accesses seen during clear; bus
// (slave modport) carrying the core mem_* port and the host valid/ready port.
// The core port always wins; the host is served only in cycles the core
// leaves idle. Reads return data exactly two cycles after the request.
module marlann_memory
  import marlann_pkg::*;
#(
  parameter int MEM_WORDS      = 4096,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  output logic             busy,
  output logic             clear_err,
  marlann_memory_if.slave  bus
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] LAST_WORD = AW'(MEM_WORDS - 1);

  marlann_state_e state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;

  logic core_act, run, host_xfer;

  logic                      ram_ren;
  logic [MARLANN_BE_W-1:0]   ram_wen;
  logic [AW-1:0]             ram_addr;
  logic [MARLANN_DATA_W-1:0] ram_wdata;
  logic [MARLANN_DATA_W-1:0] ram_rdata;

  logic vld_p0, host_p0, zero_p0;
  logic vld_p1_q, host_p1_q, zero_p1_q;
  logic [MARLANN_DATA_W-1:0] rdata_q;
  logic rvalid_q, clear_err_q;

  assign core_act       = bus.mem_ren | (|bus.mem_wen);
  assign run            = (state_q == RUN);
  assign busy           = ~run;
  assign bus.host_ready = run & ~core_act & resetn;
  assign host_xfer      = bus.host_valid & bus.host_ready;

  // High address bits alias onto the low ones; they are intentionally dropped.
  if (AW < MARLANN_ADDR_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.mem_addr[MARLANN_ADDR_W-1:AW],
                              bus.host_addr[MARLANN_ADDR_W-1:AW]};
  end

  // FSM next state: clear walks every word once, then hands over to RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == LAST_WORD) state_d = RUN;
    end
  end

  // Port mux: clear owns the RAM while busy; core reads then complete as zero.
  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = '0;
    ram_addr  = cnt_q;
    ram_wdata = '0;
    vld_p0    = 1'b0;
    host_p0   = 1'b0;
    zero_p0   = 1'b0;
    if (state_q == CLEAR) begin
      ram_wen = '1;
      vld_p0  = bus.mem_ren;
      zero_p0 = 1'b1;
    end else if (core_act) begin
      ram_ren   = bus.mem_ren;
      ram_wen   = bus.mem_wen;
      ram_addr  = bus.mem_addr[AW-1:0];
      ram_wdata = bus.mem_wdata;
      vld_p0    = bus.mem_ren;
    end else if (host_xfer) begin
      ram_ren   = (bus.host_wen == '0);
      ram_wen   = bus.host_wen;
      ram_addr  = bus.host_addr[AW-1:0];
      ram_wdata = bus.host_wdata;
      vld_p0    = (bus.host_wen == '0);
      host_p0   = 1'b1;
    end
  end

  marlann_memory_ram #(.WORDS(MEM_WORDS), .AW(AW)) u_ram (
    .clock   (clock),
    .ren_i   (ram_ren),
    .wen_i   (ram_wen),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= CLEAR_ON_RESET ? CLEAR : RUN;
      cnt_q       <= '0;
      vld_p1_q    <= 1'b0;
      host_p1_q   <= 1'b0;
      zero_p1_q   <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      clear_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!run && core_act) clear_err_q <= 1'b1;
      // p0 -> p1: RAM captures the word, tags travel alongside
      vld_p1_q  <= vld_p0;
      host_p1_q <= host_p0;
      zero_p1_q <= zero_p0;
      // p1 -> p2: output register, updated only when a read completes
      if (vld_p1_q) rdata_q <= zero_p1_q ? '0 : ram_rdata;
      rvalid_q <= vld_p1_q & host_p1_q;
    end
  end

  assign bus.mem_rdata   = rdata_q;
  assign bus.host_rdata  = rdata_q;
  assign bus.host_rvalid = rvalid_q;
  assign clear_err       = clear_err_q;

endmodule

// File: tb/tb_marlann_memory.sv
module tb_marlann_memory;
  localparam int W = 16;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  logic busy, clear_err;

  marlann_memory_if bus();

  marlann_memory #(.MEM_WORDS(W), .CLEAR_ON_RESET(1'b1)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .busy      (busy),
    .clear_err (clear_err),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory array, clear countdown, list of reads due.
  typedef struct {
    int          due;
    logic [63:0] data;
    bit          host;
  } rd_t;

  logic [63:0] m_mem [W];
  rd_t         pend[$];
  int          clear_left = 0;
  int          cyc = 0;
  bit          m_err = 0;
  bit          m_rvalid = 0;
  logic [63:0] m_rdata = '0;

  task automatic m_write(input int a, input logic [7:0] be, input logic [63:0] d);
    for (int i = 0; i < 8; i++)
      if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic drive_idle();
    bus.mem_ren = 0; bus.mem_wen = '0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.host_valid = 0; bus.host_wen = '0; bus.host_addr = '0; bus.host_wdata = '0;
  endtask

  // One clock cycle: drive at posedge+1, check, advance model across the edge.
  task automatic step(input bit ren, input logic [7:0] wen, input logic [15:0] addr,
                      input logic [63:0] wd, input bit hv, input logic [7:0] hwen,
                      input logic [15:0] haddr, input logic [63:0] hwd);
    bit core;
    int a;
    rd_t r;
    bus.mem_ren = ren; bus.mem_wen = wen; bus.mem_addr = addr; bus.mem_wdata = wd;
    bus.host_valid = hv; bus.host_wen = hwen; bus.host_addr = haddr; bus.host_wdata = hwd;
    #1;
    core = ren || (wen != 0);
    check("host_ready",  bus.host_ready,  64'(clear_left == 0 && !core));
    check("busy",        busy,            64'(clear_left > 0));
    check("mem_rdata",   bus.mem_rdata,   m_rdata);
    check("host_rdata",  bus.host_rdata,  m_rdata);
    check("host_rvalid", bus.host_rvalid, 64'(m_rvalid));
    check("clear_err",   clear_err,       64'(m_err));
    if (clear_left > 0) begin
      m_mem[W - clear_left] = '0;
      if (core) m_err = 1;
      if (ren) pend.push_back('{cyc + 2, 64'd0, 1'b0});
      clear_left--;
    end else if (core) begin
      a = int'(addr) % W;
      if (ren) pend.push_back('{cyc + 2, m_mem[a], 1'b0});
      m_write(a, wen, wd);
    end else if (hv) begin
      a = int'(haddr) % W;
      if (hwen == 0) pend.push_back('{cyc + 2, m_mem[a], 1'b1});
      else m_write(a, hwen, hwd);
    end
    @(posedge clock); #1;
    cyc++;
    m_rvalid = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      m_rdata  = r.data;
      m_rvalid = r.host;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h0, 16'h0, 64'h0, 0, 8'h0, 16'h0, 64'h0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive_idle();
    #2;
    check("rst_busy",        busy,            64'd1);
    check("rst_mem_rdata",   bus.mem_rdata,   64'd0);
    check("rst_host_rvalid", bus.host_rvalid, 64'd0);
    check("rst_host_ready",  bus.host_ready,  64'd0);
    check("rst_clear_err",   clear_err,       64'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    clear_left = W;
    pend.delete();
    m_rdata = '0; m_rvalid = 0; m_err = 0;
  endtask

  typedef struct {
    bit          ren;
    logic [7:0]  wen;
    logic [15:0] addr;
    logic [63:0] wd;
    bit          hv;
    logic [7:0]  hwen;
    logic [15:0] haddr;
    logic [63:0] hwd;
    bit          chk;
    logic [63:0] exp_rd;
    bit          exp_hrv;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // exp_* columns hold the outputs expected in the cycle the row is driven
    tbl[0]  = '{0, 8'h00, 16'h0000, 64'h0, 1, 8'hFF, 16'h0005, 64'h0123_4567_89AB_CDEF, 0, 64'h0, 0};
    tbl[1]  = '{0, 8'h00, 16'h0000, 64'h0, 1, 8'h00, 16'h0005, 64'h0, 0, 64'h0, 0};
    tbl[2]  = '{0, 8'h00, 16'h0000, 64'h0, 0, 8'h00, 16'h0000, 64'h0, 0, 64'h0, 0};
    tbl[3]  = '{0, 8'h00, 16'h0000, 64'h0, 0, 8'h00, 16'h0000, 64'h0, 1, 64'h0123_4567_89AB_CDEF, 1};
    tbl[4]  = '{0, 8'h0F, 16'h0005, 64'hFFFF_FFFF_1111_2222, 0, 8'h00, 16'h0000, 64'h0, 0, 64'h0, 0};
    tbl[5]  = '{1, 8'h00, 16'h0005, 64'h0, 0, 8'h00, 16'h0000, 64'h0, 0, 64'h0, 0};
    tbl[6]  = '{0, 8'h00, 16'h0000, 64'h0, 0, 8'h00, 16'h0000, 64'h0, 0, 64'h0, 0};
    tbl[7]  = '{0, 8'h00, 16'h0000, 64'h0, 0, 8'h00, 16'h0000, 64'h0, 1, 64'h0123_4567_1111_2222, 0};
    tbl[8]  = '{0, 8'h00, 16'h0000, 64'h0, 1, 8'hFF, 16'h0003, 64'hAA, 0, 64'h0, 0};
    tbl[9]  = '{1, 8'hFF, 16'h0013, 64'hBB, 0, 8'h00, 16'h0000, 64'h0, 0, 64'h0, 0};
    tbl[10] = '{1, 8'h00, 16'h0003, 64'h0, 0, 8'h00, 16'h0000, 64'h0, 0, 64'h0, 0};
    tbl[11] = '{0, 8'h00, 16'h0000, 64'h0, 0, 8'h00, 16'h0000, 64'h0, 1, 64'hAA, 0};
    tbl[12] = '{0, 8'h00, 16'h0000, 64'h0, 0, 8'h00, 16'h0000, 64'h0, 1, 64'hBB, 0};

    drive_idle();
    #1;
    do_reset();

    // Clear takes exactly W cycles, then every word reads back as zero.
    idle(W);
    for (int a = 0; a < W; a++) step(0, 8'h0, 16'h0, 64'h0, 1, 8'h00, 16'(a), 64'h0);
    idle(2);

    // Directed table: host write/read, partial core write, read-first + aliasing.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d_rdata", i),  bus.mem_rdata,   tbl[i].exp_rd);
        check($sformatf("tbl%0d_rvalid", i), bus.host_rvalid, 64'(tbl[i].exp_hrv));
      end
      step(tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].wd,
           tbl[i].hv, tbl[i].hwen, tbl[i].haddr, tbl[i].hwd);
    end

    // Core streams reads 0..7 while the host waits; host gets in afterwards.
    for (int a = 0; a < 8; a++)
      step(0, 8'h0, 16'h0, 64'h0, 1, 8'hFF, 16'(a), {$urandom, $urandom});
    for (int a = 0; a < 8; a++)
      step(1, 8'h0, 16'(a), 64'h0, 1, 8'h00, 16'h0009, 64'h0);
    step(0, 8'h0, 16'h0, 64'h0, 1, 8'h00, 16'h0009, 64'h0);
    idle(2);

    // Randomised mix of core and host traffic with aliased addresses.
    for (int i = 0; i < 400; i++) begin
      bit          r;
      logic [7:0]  we, hwe;
      r   = ($urandom_range(0, 3) == 0);
      we  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      hwe = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      step(r, we, 16'($urandom), {$urandom, $urandom},
           ($urandom_range(0, 1) == 1), hwe, 16'($urandom), {$urandom, $urandom});
    end
    idle(2);

    // Core accesses during clear: read returns zero, write dropped, error sticks.
    do_reset();
    idle(3);
    step(1, 8'h00, 16'h0002, 64'h0, 0, 8'h0, 16'h0, 64'h0);
    step(0, 8'hFF, 16'h0001, 64'hFFFF_FFFF_FFFF_FFFF, 0, 8'h0, 16'h0, 64'h0);
    idle(5);
    check("clear_err_sticky", clear_err, 64'd1);

    // Reset pulse mid-clear restarts the full clear.
    do_reset();
    idle(W + 2);
    step(0, 8'h0, 16'h0, 64'h0, 1, 8'h00, 16'h0001, 64'h0);
    step(0, 8'h0, 16'h0, 64'h0, 1, 8'h00, 16'h0002, 64'h0);
    idle(2);

    // Reset with a host read in flight: no rvalid ever appears.
    step(0, 8'h0, 16'h0, 64'h0, 1, 8'h00, 16'h0005, 64'h0);
    do_reset();
    idle(W + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
